// File: rtl/timer_base_gen_pkg.sv
// rtl/timer_base_gen_pkg.sv - shared addresses, CTL field positions and encodings for timer_base_gen
package timer_base_gen_pkg;

    localparam logic [15:0] CTL_ADDR_DEF = 16'h0340;
    localparam logic [15:0] R_ADDR_DEF   = 16'h0350;
    localparam logic [15:0] EX0_ADDR_DEF = 16'h0360;

    localparam int CTL_TAIFG      = 0;
    localparam int CTL_TAIE       = 1;
    localparam int CTL_TACLR      = 2;
    localparam int CTL_MC_LSB     = 4;
    localparam int CTL_ID_LSB     = 6;
    localparam int CTL_TASSEL_LSB = 8;
    localparam int CTL_CNTL_LSB   = 11;

    typedef enum logic [1:0] {MC_STOP, MC_UP, MC_CONT, MC_UPDOWN} mc_e;
    typedef enum logic [1:0] {SRC_TACLK, SRC_ACLK, SRC_SMCLK, SRC_INCLK} tassel_e;
    typedef enum logic [1:0] {CNTL_16, CNTL_12, CNTL_10, CNTL_8} cntl_e;

    // All-ones mask of the effective counter length, capped by the physical width.
    function automatic logic [15:0] len_mask(input cntl_e cntl, input int cnt_width);
        int len;
        case (cntl)
            CNTL_12: len = 12;
            CNTL_10: len = 10;
            CNTL_8:  len = 8;
            default: len = 16;
        endcase
        if (cnt_width < len) len = cnt_width;
        return 16'hFFFF >> (16 - len);
    endfunction

endpackage

// File: rtl/timer_clk_select_div.sv
// rtl/timer_clk_select_div.sv - source synchronisers, edge detect, source mux and ID/IDEX divider
module timer_clk_select_div
    import timer_base_gen_pkg::*;
#(
    parameter bit SMCLK_EQ_MCLK = 1'b1
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       taclk,
    input  logic       aclk,
    input  logic       smclk,
    input  logic       inclk,
    input  tassel_e    tassel,
    input  logic [1:0] id,
    input  logic [2:0] idex,
    input  logic       run,
    input  logic       clr,
    output logic       tick
);

    logic [3:0] src_lvl, sync1, sync2, prev, raw_edge, pulse_q;
    logic [6:0] div_cnt, div_last;
    logic       src_pulse, div_hit;

    // Bit order matches the TASSEL encoding.
    assign src_lvl = {inclk, smclk, aclk, taclk};

    always_comb begin
        raw_edge = sync2 & ~prev;
        if (SMCLK_EQ_MCLK) raw_edge[2] = 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pulse_q <= '0;
        end else begin
            sync1   <= src_lvl;
            sync2   <= sync1;
            prev    <= sync2;
            pulse_q <= raw_edge;
        end
    end

    assign src_pulse = pulse_q[tassel];
    assign div_last  = (({4'b0000, idex} + 7'd1) << id) - 7'd1;
    // >= keeps the divider sane if ID/IDEX shrink while the count is high.
    assign div_hit   = (div_cnt >= div_last);
    assign tick      = src_pulse & run & div_hit & ~clr;

    always_ff @(posedge mclk) begin
        if (reset || clr) begin
            div_cnt <= '0;
        end else if (run && src_pulse) begin
            div_cnt <= div_hit ? 7'd0 : div_cnt + 7'd1;
        end
    end

endmodule

// File: rtl/timer_base_gen.sv
// rtl/timer_base_gen.sv - parametrised timer base counter with CTL/R/EX0 registers and TAIFG handling
module timer_base_gen
    import timer_base_gen_pkg::*;
#(
    parameter int          CNT_WIDTH     = 16,
    parameter logic [15:0] CTL_ADDR      = CTL_ADDR_DEF,
    parameter logic [15:0] R_ADDR        = R_ADDR_DEF,
    parameter logic [15:0] EX0_ADDR      = EX0_ADDR_DEF,
    parameter bit          SMCLK_EQ_MCLK = 1'b1
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        TACLK,
    input  logic        ACLK,
    input  logic        SMCLK,
    input  logic        INCLK,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    input  logic        MW,
    input  logic        BW,
    input  logic        EQU0,
    input  logic        TAIFGclr,
    output logic        TimerTick,
    output logic [15:0] TAxRcurrent,
    output logic        TAxRdown,
    output logic        wTAIFG,
    output logic        wTAIE,
    output logic [15:0] MDBread
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    cntl_e                cntl;
    tassel_e              tassel;
    mc_e                  mc;
    logic [1:0]           id;
    logic [2:0]           idex;
    logic                 taie, taifg, dir_down;
    logic [CNT_WIDTH-1:0] tar;

    logic                 wr_ok, ctl_wr, r_wr, ex0_wr, div_clr, tick;
    logic [15:0]          wdata, cur_mask16, next_mask16, tar_ext;
    mc_e                  wr_mc;
    cntl_e                wr_cntl;
    logic [CNT_WIDTH-1:0] cnt_max, next_max, tar_n;
    logic                 dir_n, set_ifg, taifg_n;

    // Odd-address byte writes are dropped; even byte writes zero the high byte.
    assign wr_ok   = MW & ~(BW & MAB[0]);
    assign wdata   = BW ? {8'h00, MDBwrite[7:0]} : MDBwrite;
    assign ctl_wr  = wr_ok & (MAB[15:1] == CTL_ADDR[15:1]);
    assign r_wr    = wr_ok & (MAB[15:1] == R_ADDR[15:1]);
    assign ex0_wr  = wr_ok & (MAB[15:1] == EX0_ADDR[15:1]);
    assign wr_mc   = mc_e'(wdata[CTL_MC_LSB +: 2]);
    assign wr_cntl = cntl_e'(wdata[CTL_CNTL_LSB +: 2]);
    assign div_clr = (ctl_wr & wdata[CTL_TACLR]) | ex0_wr;

    timer_clk_select_div #(
        .SMCLK_EQ_MCLK(SMCLK_EQ_MCLK)
    ) u_clk_div (
        .mclk   (MCLK),
        .reset  (reset),
        .taclk  (TACLK),
        .aclk   (ACLK),
        .smclk  (SMCLK),
        .inclk  (INCLK),
        .tassel (tassel),
        .id     (id),
        .idex   (idex),
        .run    (mc != MC_STOP),
        .clr    (div_clr),
        .tick   (tick)
    );

    assign cur_mask16  = len_mask(cntl, CNT_WIDTH);
    assign next_mask16 = len_mask(ctl_wr ? wr_cntl : cntl, CNT_WIDTH);
    assign cnt_max     = cur_mask16[CNT_WIDTH-1:0];
    assign next_max    = next_mask16[CNT_WIDTH-1:0];

    always_comb begin
        tar_n   = tar;
        dir_n   = dir_down;
        set_ifg = 1'b0;
        if (tick) begin
            case (mc)
                MC_UP: begin
                    if (EQU0 || tar == cnt_max) begin
                        tar_n   = '0;
                        set_ifg = 1'b1;
                    end else begin
                        tar_n = tar + CNT_ONE;
                    end
                end
                MC_CONT: begin
                    if (tar == cnt_max) begin
                        tar_n   = '0;
                        set_ifg = 1'b1;
                    end else begin
                        tar_n = tar + CNT_ONE;
                    end
                end
                MC_UPDOWN: begin
                    if (dir_down) begin
                        if (tar <= CNT_ONE) begin
                            tar_n   = '0;
                            dir_n   = 1'b0;
                            set_ifg = (tar == CNT_ONE);
                        end else begin
                            tar_n = tar - CNT_ONE;
                        end
                    end else if (EQU0) begin
                        if (tar != '0) begin
                            tar_n = tar - CNT_ONE;
                            dir_n = 1'b1;
                        end
                    end else if (tar == cnt_max) begin
                        tar_n = '0;
                    end else begin
                        tar_n = tar + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
        if (r_wr) tar_n = wdata[CNT_WIDTH-1:0];
        if (ctl_wr) begin
            if (wdata[CTL_TACLR]) begin
                tar_n = '0;
                dir_n = 1'b0;
            end
            if (wr_mc != mc) dir_n = 1'b0;
        end
    end

    // Hardware set beats the IV clear, which beats a software write.
    always_comb begin
        taifg_n = taifg;
        if (ctl_wr)   taifg_n = wdata[CTL_TAIFG];
        if (TAIFGclr) taifg_n = 1'b0;
        if (set_ifg)  taifg_n = 1'b1;
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            cntl     <= CNTL_16;
            tassel   <= SRC_TACLK;
            id       <= '0;
            mc       <= MC_STOP;
            taie     <= 1'b0;
            taifg    <= 1'b0;
            idex     <= '0;
            tar      <= '0;
            dir_down <= 1'b0;
        end else begin
            if (ctl_wr) begin
                cntl   <= wr_cntl;
                tassel <= tassel_e'(wdata[CTL_TASSEL_LSB +: 2]);
                id     <= wdata[CTL_ID_LSB +: 2];
                mc     <= wr_mc;
                taie   <= wdata[CTL_TAIE];
            end
            if (ex0_wr) idex <= wdata[2:0];
            tar      <= tar_n & next_max;
            dir_down <= dir_n;
            taifg    <= taifg_n;
        end
    end

    always_comb begin
        tar_ext                = '0;
        tar_ext[CNT_WIDTH-1:0] = tar;
    end

    always_comb begin
        MDBread = '0;
        if (MAB[15:1] == CTL_ADDR[15:1])
            MDBread = {3'b000, cntl, 1'b0, tassel, id, mc, 2'b00, taie, taifg};
        else if (MAB[15:1] == R_ADDR[15:1])
            MDBread = tar_ext;
        else if (MAB[15:1] == EX0_ADDR[15:1])
            MDBread = {13'd0, idex};
    end

    assign TimerTick   = tick;
    assign TAxRcurrent = tar_ext;
    assign TAxRdown    = dir_down;
    assign wTAIFG      = taifg;
    assign wTAIE       = taie;

endmodule

// File: tb/tb_timer_base_gen.sv
// tb/tb_timer_base_gen.sv - self-checking bench for timer_base_gen
module tb_timer_base_gen;

    localparam logic [15:0] CTL = 16'h0340;
    localparam logic [15:0] R   = 16'h0350;
    localparam logic [15:0] EX0 = 16'h0360;

    logic        MCLK = 1'b0;
    logic        reset, TACLK, ACLK, SMCLK, INCLK, MW, BW, EQU0, TAIFGclr;
    logic [15:0] MAB, MDBwrite;
    logic        TimerTick, TAxRdown, wTAIFG, wTAIE;
    logic [15:0] TAxRcurrent, MDBread;

    int checks = 0;
    int errors = 0;
    int ticks;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bw;
        logic        mw;
        logic [15:0] raddr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[14];

    always #5 MCLK = ~MCLK;

    timer_base_gen dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .TACLK       (TACLK),
        .ACLK        (ACLK),
        .SMCLK       (SMCLK),
        .INCLK       (INCLK),
        .MAB         (MAB),
        .MDBwrite    (MDBwrite),
        .MW          (MW),
        .BW          (BW),
        .EQU0        (EQU0),
        .TAIFGclr    (TAIFGclr),
        .TimerTick   (TimerTick),
        .TAxRcurrent (TAxRcurrent),
        .TAxRdown    (TAxRdown),
        .wTAIFG      (wTAIFG),
        .wTAIE       (wTAIE),
        .MDBread     (MDBread)
    );

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB = addr; MDBwrite = data; BW = bw; MW = 1'b1;
        step();
        MW = 1'b0; BW = 1'b0;
    endtask

    task automatic rd_chk(input logic [15:0] addr, input logic [15:0] exp, input string name);
        MAB = addr;
        #1;
        chk(name, MDBread, exp);
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (!TimerTick && n < 100) begin
            step();
            n++;
        end
        chk(name, {15'd0, TimerTick}, 16'd1);
    endtask

    task automatic wait_cnt(input logic [15:0] v, input string name);
        int n = 0;
        while (!(TAxRcurrent == v && TimerTick) && n < 400) begin
            step();
            n++;
        end
        chk(name, TAxRcurrent, v);
    endtask

    initial begin
        reset = 1'b1; TACLK = 0; ACLK = 0; SMCLK = 0; INCLK = 0;
        MW = 0; BW = 0; EQU0 = 0; TAIFGclr = 0; MAB = '0; MDBwrite = '0;

        tbl[0]  = '{CTL,     16'hFFFF, 1'b0, 1'b1, CTL,     16'h1BF3};
        tbl[1]  = '{CTL,     16'h0000, 1'b0, 1'b1, CTL,     16'h0000};
        tbl[2]  = '{R,       16'hFFFF, 1'b0, 1'b1, R,       16'hFFFF};
        tbl[3]  = '{CTL,     16'h1800, 1'b0, 1'b1, R,       16'h00FF};
        tbl[4]  = '{CTL,     16'h0000, 1'b0, 1'b1, R,       16'h00FF};
        tbl[5]  = '{R,       16'h1234, 1'b0, 1'b1, R,       16'h1234};
        tbl[6]  = '{R,       16'hABCD, 1'b1, 1'b1, R,       16'h00CD};
        tbl[7]  = '{R + 1,   16'h00AB, 1'b1, 1'b1, R,       16'h00CD};
        tbl[8]  = '{EX0,     16'hFFFF, 1'b0, 1'b1, EX0,     16'h0007};
        tbl[9]  = '{EX0,     16'h0005, 1'b1, 1'b1, EX0,     16'h0005};
        tbl[10] = '{CTL,     16'hFF36, 1'b1, 1'b1, CTL,     16'h0032};
        tbl[11] = '{CTL,     16'h0000, 1'b0, 1'b0, R,       16'h0000};
        tbl[12] = '{CTL + 1, 16'h00FF, 1'b1, 1'b1, CTL,     16'h0032};
        tbl[13] = '{CTL,     16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};

        step(); step(); step();
        chk("rst_tick", {15'd0, TimerTick}, 16'd0);
        chk("rst_tar", TAxRcurrent, 16'h0000);
        chk("rst_flags", {13'd0, TAxRdown, wTAIFG, wTAIE}, 16'd0);
        rd_chk(CTL, 16'h0000, "rst_ctl");
        rd_chk(EX0, 16'h0000, "rst_ex0");
        reset = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            MAB = tbl[i].addr; MDBwrite = tbl[i].data; BW = tbl[i].bw; MW = tbl[i].mw;
            step();
            MW = 1'b0; BW = 1'b0;
            rd_chk(tbl[i].raddr, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // read-during-write sees the old value
        MAB = CTL; MDBwrite = 16'h1800; MW = 1'b1;
        #1;
        chk("rdw_old", MDBread, 16'h0000);
        step();
        MW = 1'b0;
        rd_chk(CTL, 16'h1800, "rdw_new");
        wr(CTL, 16'h0000, 1'b0);

        // TACLK edge -> tick exactly 3 MCLK later
        wr(EX0, 16'h0000, 1'b0);
        wr(CTL, 16'h0024, 1'b0);
        TACLK = 1'b1;
        step(); chk("lat_c1", {15'd0, TimerTick}, 16'd0);
        step(); chk("lat_c2", {15'd0, TimerTick}, 16'd0);
        step(); chk("lat_c3", {15'd0, TimerTick}, 16'd1);
        step(); chk("lat_c4", {15'd0, TimerTick}, 16'd0);
        chk("lat_tar", TAxRcurrent, 16'd1);
        TACLK = 1'b0;

        // up mode, divide by 10
        wr(EX0, 16'h0004, 1'b0);
        wr(R, 16'hFFFF, 1'b1);
        chk("up_bytewr", TAxRcurrent, 16'h00FF);
        wr(CTL, 16'h0254, 1'b0);
        chk("up_clr", TAxRcurrent, 16'h0000);
        ticks = 0;
        for (int k = 0; k < 300; k++) begin
            if (TimerTick) ticks++;
            step();
        end
        chk("up_ticks", 16'(ticks), 16'd30);
        chk("up_tar300", TAxRcurrent, 16'd30);
        chk("up_ifg0", {15'd0, wTAIFG}, 16'd0);
        EQU0 = 1'b1;
        wait_tick("up_equ_tick");
        step();
        EQU0 = 1'b0;
        chk("up_equ_tar", TAxRcurrent, 16'd0);
        chk("up_equ_ifg", {15'd0, wTAIFG}, 16'd1);
        chk("up_taie", {15'd0, wTAIE}, 16'd0);
        TAIFGclr = 1'b1; step(); TAIFGclr = 1'b0;
        chk("up_ifgclr", {15'd0, wTAIFG}, 16'd0);

        // continuous, EQU0 ignored
        wr(CTL, 16'h0264, 1'b0);
        wr(R, 16'hFFF8, 1'b0);
        EQU0 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wait_tick("cont_tick");
            step();
        end
        chk("cont_ffff", TAxRcurrent, 16'hFFFF);
        chk("cont_ifg0", {15'd0, wTAIFG}, 16'd0);
        wait_tick("cont_tick8");
        step();
        EQU0 = 1'b0;
        chk("cont_wrap", TAxRcurrent, 16'h0000);
        chk("cont_ifg1", {15'd0, wTAIFG}, 16'd1);

        // TAIFGclr colliding with an overflow
        TAIFGclr = 1'b1; step(); TAIFGclr = 1'b0;
        chk("coll_pre_clr", {15'd0, wTAIFG}, 16'd0);
        wr(R, 16'hFFFF, 1'b0);
        wait_tick("coll_tick");
        TAIFGclr = 1'b1; step(); TAIFGclr = 1'b0;
        chk("coll_ifg", {15'd0, wTAIFG}, 16'd1);
        chk("coll_tar", TAxRcurrent, 16'h0000);

        // TAxR write colliding with a tick
        wait_tick("wrtick_tick");
        wr(R, 16'h1234, 1'b0);
        chk("wrtick_tar", TAxRcurrent, 16'h1234);

        // 8-bit length, tick every cycle
        wr(EX0, 16'h0000, 1'b0);
        wr(CTL, 16'h1A24, 1'b0);
        rd_chk(CTL, 16'h1A20, "b8_ctl_rd");
        wr(R, 16'h00FD, 1'b0);
        chk("b8_tick", {15'd0, TimerTick}, 16'd1);
        step();
        step();
        chk("b8_ff", TAxRcurrent, 16'h00FF);
        chk("b8_ifg0", {15'd0, wTAIFG}, 16'd0);
        step();
        chk("b8_wrap", TAxRcurrent, 16'h0000);
        chk("b8_ifg1", {15'd0, wTAIFG}, 16'd1);

        // up-down, EQU0 at 30
        wr(CTL, 16'h0274, 1'b0);
        chk("ud_ifgclr", {15'd0, wTAIFG}, 16'd0);
        wait_cnt(16'd30, "ud_reach30");
        EQU0 = 1'b1; step(); EQU0 = 1'b0;
        chk("ud_29", TAxRcurrent, 16'd29);
        chk("ud_down", {15'd0, TAxRdown}, 16'd1);
        wait_cnt(16'd1, "ud_reach1");
        chk("ud_ifg0", {15'd0, wTAIFG}, 16'd0);
        step();
        chk("ud_zero", TAxRcurrent, 16'd0);
        chk("ud_ifg1", {15'd0, wTAIFG}, 16'd1);
        chk("ud_up", {15'd0, TAxRdown}, 16'd0);

        // reset mid-count
        wait_cnt(16'd50, "mid_reach50");
        MAB = CTL;
        reset = 1'b1;
        step();
        chk("mid_tar", TAxRcurrent, 16'd0);
        chk("mid_outs", {12'd0, TimerTick, TAxRdown, wTAIFG, wTAIE}, 16'd0);
        chk("mid_ctl", MDBread, 16'h0000);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
